// File: rtl/game_controller.sv
// rtl/game_controller.sv - tic-tac-toe move arbiter with win/draw detection
// Optional macro GAME_TURN_TIMEOUT_EN adds a per-turn auto-move timer.
module game_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic [3:0]  cell_sel,
  input  logic        move_valid,
  input  logic        new_game,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  game_state,
  output logic [7:0]  win_line,
  output logic        move_ack,
  output logic        move_err,
  output logic        timeout
);

  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

  localparam logic [1:0] GS_PLAYING = 2'b00;
  localparam logic [1:0] GS_X_WIN   = 2'b01;
  localparam logic [1:0] GS_O_WIN   = 2'b10;
  localparam logic [1:0] GS_DRAW    = 2'b11;
  localparam logic [1:0] MARK_X     = 2'b01;
  localparam logic [1:0] MARK_O     = 2'b10;

  state_t      state_q, state_d;
  logic [17:0] board_d;
  logic        turn_d;
  logic [1:0]  game_state_d;
  logic [7:0]  win_line_d;
  logic        move_ack_d, move_err_d, timeout_d;
  logic [3:0]  move_cnt_q, move_cnt_d;

  logic [1:0]  mark;
  logic [8:0]  empty, own, sel_oh, place_oh;
  logic        sel_ok, place;
  logic [7:0]  line_hit, win_first;

  assign mark = turn ? MARK_O : MARK_X;

  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < 9; i++) begin
      empty[i]  = (board[2*i +: 2] == 2'b00);
      own[i]    = (board[2*i +: 2] == mark);
      sel_oh[i] = (cell_sel == 4'(i));
      if (sel_oh[i] && empty[i]) sel_ok = 1'b1;
    end
  end

  // Lines scored for the player whose mark is current; in CHECK that is the one who just moved.
  assign line_hit[0] = own[0] & own[1] & own[2];
  assign line_hit[1] = own[3] & own[4] & own[5];
  assign line_hit[2] = own[6] & own[7] & own[8];
  assign line_hit[3] = own[0] & own[3] & own[6];
  assign line_hit[4] = own[1] & own[4] & own[7];
  assign line_hit[5] = own[2] & own[5] & own[8];
  assign line_hit[6] = own[0] & own[4] & own[8];
  assign line_hit[7] = own[2] & own[4] & own[6];
  assign win_first   = line_hit & (~line_hit + 8'd1);

`ifdef GAME_TURN_TIMEOUT_EN
  localparam logic [31:0] TCNT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] tcnt_q, tcnt_d;
  logic [8:0]  first_empty_oh;
  logic        found;

  always_comb begin
    found          = 1'b0;
    first_empty_oh = '0;
    for (int i = 0; i < 9; i++) begin
      if (empty[i] && !found) begin
        first_empty_oh[i] = 1'b1;
        found             = 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    board_d      = board;
    turn_d       = turn;
    game_state_d = game_state;
    win_line_d   = win_line;
    move_cnt_d   = move_cnt_q;
    move_ack_d   = 1'b0;
    move_err_d   = 1'b0;
    timeout_d    = 1'b0;
    place        = 1'b0;
    place_oh     = sel_oh;
`ifdef GAME_TURN_TIMEOUT_EN
    tcnt_d       = '0;
`endif
    if (new_game) begin
      state_d      = PLAY;
      board_d      = '0;
      turn_d       = 1'b0;
      game_state_d = GS_PLAYING;
      win_line_d   = '0;
      move_cnt_d   = '0;
    end else begin
      case (state_q)
        PLAY: begin
`ifdef GAME_TURN_TIMEOUT_EN
          tcnt_d = (tcnt_q < TCNT_LAST) ? tcnt_q + 32'd1 : tcnt_q;
`endif
          if (move_valid) begin
            if (sel_ok) place = 1'b1;
            else        move_err_d = 1'b1;
          end
`ifdef GAME_TURN_TIMEOUT_EN
          // A real request in the expiry cycle always beats the auto-move.
          else if (tcnt_q >= TCNT_LAST) begin
            place     = 1'b1;
            place_oh  = first_empty_oh;
            timeout_d = 1'b1;
          end
`endif
          if (place) begin
            for (int i = 0; i < 9; i++) begin
              if (place_oh[i]) board_d[2*i +: 2] = mark;
            end
            move_ack_d = 1'b1;
            move_cnt_d = move_cnt_q + 4'd1;
            state_d    = CHECK;
`ifdef GAME_TURN_TIMEOUT_EN
            tcnt_d     = '0;
`endif
          end
        end
        CHECK: begin
          move_err_d = move_valid;
          if (|line_hit) begin
            game_state_d = turn ? GS_O_WIN : GS_X_WIN;
            win_line_d   = win_first;
            state_d      = DONE;
          end else if (move_cnt_q == 4'd9) begin
            game_state_d = GS_DRAW;
            state_d      = DONE;
          end else begin
            turn_d  = ~turn;
            state_d = PLAY;
          end
        end
        DONE: move_err_d = move_valid;
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PLAY;
      board      <= '0;
      turn       <= 1'b0;
      game_state <= GS_PLAYING;
      win_line   <= '0;
      move_cnt_q <= '0;
      move_ack   <= 1'b0;
      move_err   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      board      <= board_d;
      turn       <= turn_d;
      game_state <= game_state_d;
      win_line   <= win_line_d;
      move_cnt_q <= move_cnt_d;
      move_ack   <= move_ack_d;
      move_err   <= move_err_d;
      timeout    <= timeout_d;
    end
  end

`ifdef GAME_TURN_TIMEOUT_EN
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end
`endif

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - directed self-checking bench for game_controller
module tb_game_controller;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  cell_sel = 4'd0;
  logic        move_valid = 1'b0;
  logic        new_game = 1'b0;
  logic [17:0] board;
  logic        turn;
  logic [1:0]  game_state;
  logic [7:0]  win_line;
  logic        move_ack, move_err, timeout;

  int checks = 0;
  int failures = 0;

  game_controller #(.TIMEOUT_CYCLES(16)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .cell_sel   (cell_sel),
    .move_valid (move_valid),
    .new_game   (new_game),
    .board      (board),
    .turn       (turn),
    .game_state (game_state),
    .win_line   (win_line),
    .move_ack   (move_ack),
    .move_err   (move_err),
    .timeout    (timeout)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic play(input logic [3:0] c, output logic ack, output logic err,
                      output logic turn_mid, output logic [1:0] gs_mid);
    @(negedge CLOCK_50);
    cell_sel   = c;
    move_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    ack = move_ack; err = move_err; turn_mid = turn; gs_mid = game_state;
    move_valid = 1'b0;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic start_new_game();
    @(negedge CLOCK_50);
    new_game = 1'b1;
    @(posedge CLOCK_50); #1;
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (board !== 18'h0) begin failures++; $display("FAIL reset_board got=%h exp=0", board); end
    checks++; if (turn !== 1'b0) begin failures++; $display("FAIL reset_turn got=%b exp=0", turn); end
    checks++; if (game_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", game_state); end
    checks++; if ({win_line, move_ack, move_err, timeout} !== 11'h0) begin failures++;
      $display("FAIL reset_flags got=%h exp=0", {win_line, move_ack, move_err, timeout}); end
    @(negedge CLOCK_50);
    rst_n = 1'b1;
  endtask

  task automatic test_x_row_win();
    logic [3:0] seq [5];
    logic ack, err, tm; logic [1:0] gm;
    seq = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
    for (int i = 0; i < 5; i++) begin
      play(seq[i], ack, err, tm, gm);
      checks++; if (ack !== 1'b1 || err !== 1'b0) begin failures++;
        $display("FAIL row_ack move=%0d got ack=%b err=%b exp ack=1 err=0", i, ack, err); end
      if (i == 0) begin
        checks++; if (tm !== 1'b0 || gm !== 2'b00) begin failures++;
          $display("FAIL latency_mid got turn=%b state=%b exp turn=0 state=00", tm, gm); end
      end
      checks++; if (turn !== ((i == 4) ? 1'b0 : 1'((i + 1) % 2))) begin failures++;
        $display("FAIL row_turn move=%0d got=%b", i, turn); end
    end
    checks++; if (board !== 18'h00295) begin failures++; $display("FAIL row_board got=%h exp=00295", board); end
    checks++; if (game_state !== 2'b01) begin failures++; $display("FAIL row_state got=%b exp=01", game_state); end
    checks++; if (win_line !== 8'h01) begin failures++; $display("FAIL row_win_line got=%h exp=01", win_line); end
  endtask

  task automatic test_done_hold();
    logic ack, err, tm; logic [1:0] gm;
    play(4'd5, ack, err, tm, gm);
    checks++; if (ack !== 1'b0 || err !== 1'b1) begin failures++;
      $display("FAIL done_move got ack=%b err=%b exp ack=0 err=1", ack, err); end
    repeat (5) @(posedge CLOCK_50);
    #1;
    checks++; if (board !== 18'h00295 || game_state !== 2'b01 || win_line !== 8'h01) begin failures++;
      $display("FAIL done_hold got board=%h state=%b line=%h", board, game_state, win_line); end
  endtask

  task automatic test_reject();
    logic ack, err, tm; logic [1:0] gm;
    start_new_game();
    play(4'd4, ack, err, tm, gm);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL reject_first got ack=%b exp=1", ack); end
    play(4'd4, ack, err, tm, gm);
    checks++; if (ack !== 1'b0 || err !== 1'b1) begin failures++;
      $display("FAIL reject_occupied got ack=%b err=%b exp ack=0 err=1", ack, err); end
    checks++; if (board !== 18'h00100 || turn !== 1'b1) begin failures++;
      $display("FAIL reject_board got board=%h turn=%b exp 00100/1", board, turn); end
    play(4'd9, ack, err, tm, gm);
    checks++; if (ack !== 1'b0 || err !== 1'b1) begin failures++;
      $display("FAIL reject_range got ack=%b err=%b exp ack=0 err=1", ack, err); end
    checks++; if (board !== 18'h00100 || game_state !== 2'b00) begin failures++;
      $display("FAIL reject_range_board got board=%h state=%b", board, game_state); end
  endtask

  task automatic test_back_to_back();
    start_new_game();
    @(negedge CLOCK_50);
    cell_sel = 4'd0; move_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    checks++; if (move_ack !== 1'b1) begin failures++; $display("FAIL b2b_first got ack=%b exp=1", move_ack); end
    cell_sel = 4'd1;
    @(posedge CLOCK_50); #1;
    move_valid = 1'b0;
    checks++; if (move_ack !== 1'b0 || move_err !== 1'b1) begin failures++;
      $display("FAIL b2b_check got ack=%b err=%b exp ack=0 err=1", move_ack, move_err); end
    checks++; if (board !== 18'h00001 || turn !== 1'b1) begin failures++;
      $display("FAIL b2b_board got board=%h turn=%b exp 00001/1", board, turn); end
  endtask

  task automatic test_draw();
    logic [3:0] seq [9];
    logic ack, err, tm; logic [1:0] gm;
    int acks = 0;
    int errs = 0;
    seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    start_new_game();
    for (int i = 0; i < 9; i++) begin
      play(seq[i], ack, err, tm, gm);
      if (ack === 1'b1) acks++;
      if (err === 1'b1) errs++;
    end
    checks++; if (acks != 9 || errs != 0) begin failures++;
      $display("FAIL draw_acks got acks=%0d errs=%0d exp 9/0", acks, errs); end
    checks++; if (board !== 18'h16A59) begin failures++; $display("FAIL draw_board got=%h exp=16A59", board); end
    checks++; if (game_state !== 2'b11 || win_line !== 8'h00) begin failures++;
      $display("FAIL draw_state got state=%b line=%h exp 11/00", game_state, win_line); end
  endtask

  task automatic test_win_on_ninth();
    logic [3:0] seq [9];
    logic ack, err, tm; logic [1:0] gm;
    seq = '{4'd6, 4'd0, 4'd7, 4'd2, 4'd1, 4'd3, 4'd5, 4'd4, 4'd8};
    start_new_game();
    for (int i = 0; i < 9; i++) play(seq[i], ack, err, tm, gm);
    checks++; if (game_state !== 2'b01 || win_line !== 8'h04 || turn !== 1'b0) begin failures++;
      $display("FAIL ninth_win got state=%b line=%h turn=%b exp 01/04/0", game_state, win_line, turn); end
  endtask

  task automatic test_new_game_priority();
    logic ack, err, tm; logic [1:0] gm;
    @(negedge CLOCK_50);
    new_game = 1'b1; move_valid = 1'b1; cell_sel = 4'd5;
    @(posedge CLOCK_50); #1;
    new_game = 1'b0; move_valid = 1'b0;
    checks++; if (move_ack !== 1'b0 || move_err !== 1'b0) begin failures++;
      $display("FAIL ng_pulse got ack=%b err=%b exp 0/0", move_ack, move_err); end
    checks++; if (board !== 18'h0 || turn !== 1'b0 || game_state !== 2'b00 || win_line !== 8'h00) begin failures++;
      $display("FAIL ng_clear got board=%h turn=%b state=%b line=%h", board, turn, game_state, win_line); end
    play(4'd5, ack, err, tm, gm);
    checks++; if (ack !== 1'b1 || board !== 18'h00400) begin failures++;
      $display("FAIL ng_next got ack=%b board=%h exp 1/00400", ack, board); end
  endtask

  task automatic test_reset_mid_check();
    logic ack, err, tm; logic [1:0] gm;
    @(negedge CLOCK_50);
    cell_sel = 4'd2; move_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    move_valid = 1'b0;
    checks++; if (move_ack !== 1'b1) begin failures++; $display("FAIL rmc_ack got=%b exp=1", move_ack); end
    rst_n = 1'b0;
    #1;
    checks++; if (board !== 18'h0 || turn !== 1'b0 || move_ack !== 1'b0) begin failures++;
      $display("FAIL rmc_clear got board=%h turn=%b ack=%b", board, turn, move_ack); end
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    checks++; if (board !== 18'h0 || turn !== 1'b0 || game_state !== 2'b00) begin failures++;
      $display("FAIL rmc_after got board=%h turn=%b state=%b", board, turn, game_state); end
    play(4'd2, ack, err, tm, gm);
    checks++; if (ack !== 1'b1 || board !== 18'h00010 || turn !== 1'b1) begin failures++;
      $display("FAIL rmc_replay got ack=%b board=%h turn=%b exp 1/00010/1", ack, board, turn); end
  endtask

  task automatic test_timeout();
    logic ack, err, tm; logic [1:0] gm;
    start_new_game();
    play(4'd0, ack, err, tm, gm);
    play(4'd1, ack, err, tm, gm);
`ifdef GAME_TURN_TIMEOUT_EN
    begin
      int n = 0;
      bit seen = 1'b0;
      while (n < 40 && !seen) begin
        @(posedge CLOCK_50); #1;
        n++;
        if (timeout === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen || n != 16) begin failures++;
        $display("FAIL to_pulse got seen=%b edges=%0d exp 1/16", seen, n); end
      checks++; if (move_ack !== 1'b1 || board !== 18'h00019 || turn !== 1'b0) begin failures++;
        $display("FAIL to_move got ack=%b board=%h turn=%b exp 1/00019/0", move_ack, board, turn); end
      @(posedge CLOCK_50); #1;
      checks++; if (turn !== 1'b1 || timeout !== 1'b0) begin failures++;
        $display("FAIL to_turn got turn=%b timeout=%b exp 1/0", turn, timeout); end
    end
`else
    begin
      int highs = 0;
      repeat (40) begin
        @(posedge CLOCK_50); #1;
        if (timeout !== 1'b0 || move_ack !== 1'b0) highs++;
      end
      checks++; if (highs != 0) begin failures++; $display("FAIL to_idle got pulses=%0d exp=0", highs); end
      checks++; if (board !== 18'h00009 || turn !== 1'b0) begin failures++;
        $display("FAIL to_idle_board got board=%h turn=%b exp 00009/0", board, turn); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_x_row_win();
    test_done_hold();
    test_reject();
    test_back_to_back();
    test_draw();
    test_win_on_ninth();
    test_new_game_priority();
    test_reset_mid_check();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 500000000, sets the per-turn auto-move limit in clocks (10 s at 50 MHz); used only when the timeout feature is compiled in.
REQ-002 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cell_sel  input  4  target cell, 0-8, row-major (0 = top-left, 8 = bottom-right).
REQ-005 move_valid  input  1  one-cycle request to place the current player's mark at cell_sel.
REQ-006 new_game  input  1  one-cycle request to clear the board and restart.
REQ-007 board  output  18  cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O, 11 never driven; feeds the video controller.
REQ-008 turn  output  1  player to move: 0 = X, 1 = O.
REQ-009 game_state  output  2  00 PLAYING, 01 X_WIN, 10 O_WIN, 11 DRAW.
REQ-010 win_line  output  8  one-hot winning line; bits 0-2 rows, 3-5 columns, 6 main diagonal (0,4,8), 7 anti-diagonal (2,4,6); all zero unless a win is declared.
REQ-011 move_ack  output  1  one-cycle pulse: move accepted.
REQ-012 move_err  output  1  one-cycle pulse: move rejected.
REQ-013 timeout  output  1  one-cycle pulse: auto-move performed.

Function
REQ-014 FSM states: PLAY, CHECK, DONE; all outputs registered.
REQ-015 PLAY + move_valid + cell_sel <= 8 + target cell empty: on the next edge, write the mark, pulse move_ack, increment the 4-bit move count, and enter CHECK.
REQ-016 A rejected move (cell_sel > 8, occupied cell, or state CHECK/DONE) pulses move_err on the next edge; board, turn and state are unchanged.
REQ-017 CHECK lasts exactly one cycle and evaluates all 8 lines for the player who just moved.
REQ-018 Win: set game_state to that player's win code, set win_line, enter DONE; turn is not toggled.
REQ-019 No win and move count = 9: game_state = DRAW, enter DONE.
REQ-020 Otherwise toggle turn and return to PLAY.
REQ-021 Win takes priority over draw when the ninth move completes a line.
REQ-022 Latency: move_valid at edge N gives board/move_ack at N+1 and game_state/turn/win_line at N+2.
REQ-023 DONE holds board and results indefinitely; only new_game or reset leaves it.
REQ-024 new_game in any state: on the next edge, clear the board, set turn = X, game_state = PLAYING, win_line = 0, move count = 0, state = PLAY.
REQ-025 new_game has priority over a simultaneous move_valid; no ack or err pulse is produced for that move.

Reset
REQ-026 rst_n low immediately forces: board 0, turn 0, game_state 00, win_line 0, move_ack 0, move_err 0, timeout 0, move count 0, timeout counter 0, state PLAY.
REQ-027 Reset asserted mid-CHECK discards the pending evaluation; the placed mark is cleared.
REQ-028 Deassertion is used as-is; no internal synchronizer.

Configuration
REQ-029 Macro GAME_TURN_TIMEOUT_EN: when defined, a counter runs only in PLAY and is cleared by accepted moves, new_game and entry to PLAY.
REQ-030 With the macro, reaching TIMEOUT_CYCLES-1 without a move places the current player's mark in the lowest-index empty cell, pulses both timeout and move_ack, and enters CHECK.
REQ-031 With the macro, a move_valid in the same cycle as expiry wins; no auto-move occurs.
REQ-032 Without the macro, no counter is built, timeout is tied to 0, and play waits forever.

Verification
REQ-033 Reset, then X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 -> game_state 01, win_line 00000001, turn 0, DONE.
REQ-034 O plays into the occupied cell 4 -> move_err pulse, board unchanged; cell_sel = 9 -> move_err.
REQ-035 Sequence 0,1,2,4,3,5,7,6,8 -> game_state 11, win_line 0, 9 acks.
REQ-036 move_valid and new_game in the same cycle while in DONE -> board 0, turn 0, game_state 00, no ack or err pulse.
REQ-037 With GAME_TURN_TIMEOUT_EN and TIMEOUT_CYCLES = 16, cells 0 and 1 filled, idle 16 clocks -> timeout pulse, cell 2 = current player's mark, turn toggles 2 clocks later.
